// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package hazard_stall_controller_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned DEF_MUL_LATENCY = 4;
  localparam int unsigned DEF_DIV_LATENCY = 8;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_stall_controller_md_latency_counter.sv
// Down-counter tracking remaining MULT/DIV busy cycles; load wins over decrement.
module md_latency_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             is_zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_en) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero_c = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage sequencing: load-use and HI/LO stalls, MULT/DIV issue tracking, branch flush.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int unsigned DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic              ID_IsMulDiv,
  input  logic              ID_IsDiv,
  input  logic              ID_ReadsHiLo,
  input  logic              EX_MemRead,
  input  logic [REG_W-1:0]  EX_WriteReg,
  input  logic              BranchTaken,
  output logic              PCWrite,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic              MD_Start,
  output logic              MD_Busy,
  output logic [PERF_W-1:0] StallCount
);

  md_state_e         state_q;
  md_state_e         state_d;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;

  logic             loaduse_c;
  logic             hilostall_c;
  logic             stall_cycle_c;
  logic             cnt_load_c;
  logic             cnt_dec_c;
  logic             cnt_zero_c;
  logic [CNT_W-1:0] cnt_load_val_c;

  // Register 0 is hard-wired, so a load targeting it can never create a hazard.
  always_comb begin
    loaduse_c = EX_MemRead && (EX_WriteReg != REG_ZERO) &&
                ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                 (ID_UsesRt && (ID_Rt == EX_WriteReg)));
    hilostall_c    = (state_q == ST_MD_BUSY) && (ID_IsMulDiv || ID_ReadsHiLo);
    cnt_load_val_c = ID_IsDiv ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
  end

  always_comb begin
    state_d       = state_q;
    PCWrite       = 1'b1;
    IFID_Write    = 1'b1;
    IFID_Flush    = 1'b0;
    IDEX_Bubble   = 1'b0;
    MD_Start      = 1'b0;
    cnt_load_c    = 1'b0;
    cnt_dec_c     = 1'b0;
    stall_cycle_c = 1'b0;
    if (!Rst) begin
      if (BranchTaken) begin
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
      end else if (loaduse_c || hilostall_c) begin
        PCWrite       = 1'b0;
        IFID_Write    = 1'b0;
        IDEX_Bubble   = 1'b1;
        stall_cycle_c = 1'b1;
      end
      // An in-flight op is older than any branch, so MD_BUSY ignores BranchTaken.
      case (state_q)
        ST_RUN: begin
          if (!BranchTaken && !loaduse_c && ID_IsMulDiv) begin
            MD_Start   = 1'b1;
            cnt_load_c = 1'b1;
            state_d    = ST_MD_BUSY;
          end
        end
        ST_MD_BUSY: begin
          if (cnt_zero_c) begin
            state_d = ST_RUN;
          end else begin
            cnt_dec_c = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cycle_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  md_latency_counter #(
    .CNT_W (CNT_W)
  ) u_md_cnt (
    .Clk       (Clk),
    .Rst       (Rst),
    .load_en   (cnt_load_c),
    .load_val  (cnt_load_val_c),
    .dec_en    (cnt_dec_c),
    .is_zero_c (cnt_zero_c)
  );

  assign MD_Busy    = !Rst && (state_q == ST_MD_BUSY);
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with a queue-based expected-result scoreboard.
module tb_hazard_stall_controller;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
  logic        ID_UsesRs, ID_UsesRt, ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo;
  logic        EX_MemRead, BranchTaken;
  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, MD_Start, MD_Busy;
  logic [15:0] StallCount;

  typedef struct {
    string       tag;
    logic        pcw, ifw, flush, bub, start, busy;
    logic [15:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_sc = '0;

  hazard_stall_controller dut (
    .Clk(Clk), .Rst(Rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsMulDiv(ID_IsMulDiv), .ID_IsDiv(ID_IsDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .MD_Start(MD_Start), .MD_Busy(MD_Busy),
    .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string fld, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic md, input logic dv, input logic hl,
                        input logic mr, input logic [4:0] wr, input logic bt);
    ID_Rs = rs; ID_UsesRs = urs; ID_Rt = rt; ID_UsesRt = urt;
    ID_IsMulDiv = md; ID_IsDiv = dv; ID_ReadsHiLo = hl;
    EX_MemRead = mr; EX_WriteReg = wr; BranchTaken = bt;
  endtask

  // Push expectation, compare at negedge, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic pcw, input logic ifw, input logic fl,
                      input logic bub, input logic st, input logic busy);
    exp_t e;
    exp_t g;
    e.tag = tag; e.pcw = pcw; e.ifw = ifw; e.flush = fl; e.bub = bub;
    e.start = st; e.busy = busy; e.sc = exp_sc;
    exp_q.push_back(e);
    @(negedge Clk);
    g = exp_q.pop_front();
    chk(g.tag, "PCWrite",     16'(PCWrite),     16'(g.pcw));
    chk(g.tag, "IFID_Write",  16'(IFID_Write),  16'(g.ifw));
    chk(g.tag, "IFID_Flush",  16'(IFID_Flush),  16'(g.flush));
    chk(g.tag, "IDEX_Bubble", 16'(IDEX_Bubble), 16'(g.bub));
    chk(g.tag, "MD_Start",    16'(MD_Start),    16'(g.start));
    chk(g.tag, "MD_Busy",     16'(MD_Busy),     16'(g.busy));
    chk(g.tag, "StallCount",  StallCount,       g.sc);
    if (Rst) exp_sc = '0;
    else if (g.bub && !g.flush) exp_sc = exp_sc + 16'd1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1;
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    step("reset", 1, 1, 0, 0, 0, 0);
    Rst = 1'b0;

    step("idle", 1, 1, 0, 0, 0, 0);
    set_in(5'd8, 1, 5'd3, 0, 0, 0, 0, 1, 5'd8, 0);
    step("loaduse_rs", 0, 0, 0, 1, 0, 0);
    set_in(5'd8, 1, 5'd3, 0, 0, 0, 0, 0, 5'd8, 0);
    step("loaduse_release", 1, 1, 0, 0, 0, 0);
    set_in(5'd8, 1, 5'd9, 1, 0, 0, 0, 1, 5'd9, 0);
    step("loaduse_rt", 0, 0, 0, 1, 0, 0);
    set_in(5'd0, 1, 5'd0, 1, 0, 0, 0, 1, 5'd0, 0);
    step("zero_reg", 1, 1, 0, 0, 0, 0);
    set_in(5'd6, 1, 5'd5, 0, 0, 0, 0, 1, 5'd5, 0);
    step("unused_rt", 1, 1, 0, 0, 0, 0);
    set_in(5'd8, 1, 5'd0, 0, 1, 0, 0, 1, 5'd8, 1);
    step("branch_prio", 1, 1, 1, 1, 0, 0);

    set_in(5'd1, 1, 5'd2, 1, 1, 0, 0, 0, 5'd0, 0);
    step("mult_issue", 1, 1, 0, 0, 1, 0);
    set_in(5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
    for (int i = 0; i < 4; i++) step("mflo_stall", 0, 0, 0, 1, 0, 1);
    step("mflo_pass", 1, 1, 0, 0, 0, 0);

    set_in(5'd1, 1, 5'd2, 1, 1, 0, 0, 0, 5'd0, 0);
    step("mult2_issue", 1, 1, 0, 0, 1, 0);
    set_in(5'd4, 1, 5'd5, 1, 0, 0, 0, 0, 5'd0, 0);
    step("busy_flow", 1, 1, 0, 0, 0, 1);
    set_in(5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1);
    step("busy_branch", 1, 1, 1, 1, 0, 1);
    set_in(5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);
    step("busy_tail3", 1, 1, 0, 0, 0, 1);
    step("busy_tail4", 1, 1, 0, 0, 0, 1);
    step("mult2_done", 1, 1, 0, 0, 0, 0);

    set_in(5'd1, 1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0);
    step("div_issue", 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step("div2_wait", 0, 0, 0, 1, 0, 1);
    step("div2_issue", 1, 1, 0, 0, 1, 0);

    set_in(5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0);
    step("div2_busy1", 1, 1, 0, 0, 0, 1);
    step("div2_busy2", 1, 1, 0, 0, 0, 1);
    Rst = 1'b1;
    set_in(5'd8, 1, 5'd0, 0, 1, 1, 1, 1, 5'd8, 0);
    step("rst_mid_div", 1, 1, 0, 0, 0, 0);
    Rst = 1'b0;
    set_in(5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
    step("after_rst", 1, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
